round_robin_arbiter: RTL

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/arbiter_pkg.sv | 10 +
 rtl/rotating_priority_encoder.sv | 41 ++++
 rtl/round_robin_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin arbiter: the grant FSM state encoding.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rotating_priority_encoder.sv
// Combinational search: first set bit of vector at or after start, wrapping
// modulo PORTCOUNT.
module rotating_priority_encoder #(
    parameter int PORTCOUNT     = 4,
    parameter int PORTADDRWIDTH = $clog2(PORTCOUNT)
) (
    input  logic [PORTCOUNT-1:0]     vector,
    input  logic [PORTADDRWIDTH-1:0] start,
    output logic                     found,
    output logic [PORTADDRWIDTH-1:0] index,
    output logic [PORTCOUNT-1:0]     onehot
);

    localparam logic [PORTADDRWIDTH:0] COUNT = (PORTADDRWIDTH+1)'(PORTCOUNT);
    localparam logic [PORTCOUNT-1:0]   ONE   = PORTCOUNT'(1);

    logic [2*PORTCOUNT-1:0] doubled;
    logic [PORTCOUNT-1:0]   rotated;
    logic [PORTADDRWIDTH:0] sum;

    // Bit k of rotated corresponds to port (start + k) mod PORTCOUNT.
    assign doubled = {vector, vector} >> start;
    assign rotated = doubled[PORTCOUNT-1:0];

    always_comb begin
        found = 1'b0;
        sum   = '0;
        for (int k = PORTCOUNT - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, start} + (PORTADDRWIDTH+1)'(k);
            end
        end
        if (sum >= COUNT) begin
            sum = sum - COUNT;
        end
        index  = sum[PORTADDRWIDTH-1:0];
        onehot = found ? (ONE << index) : '0;
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with per-port masking, burst lock and a ready/valid
// grant handshake; all grant outputs are registered.
module round_robin_arbiter
    import arbiter_pkg::*;
#(
    parameter int PORTCOUNT     = 4,
    parameter int PORTADDRWIDTH = $clog2(PORTCOUNT)
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     clk_en,
    input  logic [PORTCOUNT-1:0]     ReqVector,
    input  logic [PORTCOUNT-1:0]     LockVector,
    input  logic [PORTCOUNT-1:0]     PortMask,
    input  logic                     GrantReady,
    output logic                     GrantValid,
    output logic [PORTCOUNT-1:0]     GrantOneHot,
    output logic [PORTADDRWIDTH-1:0] GrantIndex
);

    localparam logic [PORTADDRWIDTH-1:0] LAST_PORT = PORTADDRWIDTH'(PORTCOUNT - 1);

    arb_state_e               state;
    logic [PORTADDRWIDTH-1:0] last_grant;
    logic [PORTCOUNT-1:0]     eligible;
    logic [PORTCOUNT-1:0]     search_vector;
    logic [PORTADDRWIDTH-1:0] search_start;
    logic                     found;
    logic [PORTADDRWIDTH-1:0] found_index;
    logic [PORTCOUNT-1:0]     found_onehot;
    logic                     granted_req;
    logic                     granted_lock;
    logic                     handshake;
    logic                     abort;
    logic                     rescan;

    function automatic logic [PORTADDRWIDTH-1:0] next_port(input logic [PORTADDRWIDTH-1:0] p);
        return (p == LAST_PORT) ? '0 : p + 1'b1;
    endfunction

    assign eligible     = ReqVector & PortMask;
    assign granted_req  = |(ReqVector & GrantOneHot);
    assign granted_lock = |(LockVector & GrantOneHot);
    assign handshake    = GrantValid & GrantReady;
    assign abort        = (state != IDLE) && !granted_req;

    // Fresh arbitration from the stored pointer when idle or aborting; on a
    // releasing handshake the just-served port becomes the pointer and is excluded.
    assign rescan        = (state == IDLE) || abort;
    assign search_start  = rescan ? next_port(last_grant) : next_port(GrantIndex);
    assign search_vector = rescan ? eligible : (eligible & ~GrantOneHot);

    rotating_priority_encoder #(
        .PORTCOUNT    (PORTCOUNT),
        .PORTADDRWIDTH(PORTADDRWIDTH)
    ) u_encoder (
        .vector(search_vector),
        .start (search_start),
        .found (found),
        .index (found_index),
        .onehot(found_onehot)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state       <= IDLE;
            last_grant  <= LAST_PORT;
            GrantValid  <= 1'b0;
            GrantOneHot <= '0;
            GrantIndex  <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        GrantValid  <= 1'b1;
                        GrantOneHot <= found_onehot;
                        GrantIndex  <= found_index;
                    end
                end
                GRANT, LOCK: begin
                    if (abort || (handshake && !granted_lock)) begin
                        if (!abort) begin
                            last_grant <= GrantIndex;
                        end
                        if (found) begin
                            state       <= GRANT;
                            GrantValid  <= 1'b1;
                            GrantOneHot <= found_onehot;
                            GrantIndex  <= found_index;
                        end else begin
                            state       <= IDLE;
                            GrantValid  <= 1'b0;
                            GrantOneHot <= '0;
                            GrantIndex  <= '0;
                        end
                    end else if (handshake) begin
                        state <= LOCK;
                    end
                end
                default: begin
                    state       <= IDLE;
                    GrantValid  <= 1'b0;
                    GrantOneHot <= '0;
                    GrantIndex  <= '0;
                end
            endcase
        end
    end

endmodule
